// File: rtl/cmp_msb_serial.sv
// Multi-cycle magnitude comparator: scans A vs B one chunk per cycle, MSB chunk first.
module cmp_msb_serial #(
  parameter int unsigned width      = 32,
  parameter int unsigned chunk      = 8,
  parameter bit          early_exit = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic             tc_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             lt_o,
  output logic             eq_o,
  output logic             gt_o
);

  localparam int unsigned NC = width / chunk;
  localparam int unsigned IW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NC - 1);

  // Reject geometries where the operand does not split into whole chunks.
  if (chunk < 1 || chunk > width || (width % chunk) != 0) begin : g_bad_geometry
    $error("cmp_msb_serial: width must be a positive multiple of chunk");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_n;
  logic [width-1:0] a_q, a_n;
  logic [width-1:0] b_q, b_n;
  logic             tc_q, tc_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic             dgt_q, dgt_n;
  logic             dlt_q, dlt_n;
  logic             ready_n, valid_n, lt_n, eq_n, gt_n;

  logic [chunk-1:0] slice_a, slice_b, top_mask;
  logic             slice_gt, slice_lt, new_dec;

  // Current slice, with the sign bit flipped on the top slice so signed order maps to unsigned order.
  always_comb begin
    top_mask = '0;
    top_mask[chunk-1] = tc_q && (idx_q == IDX_TOP);
    slice_a  = chunk'(a_q >> (32'(idx_q) * chunk)) ^ top_mask;
    slice_b  = chunk'(b_q >> (32'(idx_q) * chunk)) ^ top_mask;
    slice_gt = slice_a > slice_b;
    slice_lt = slice_a < slice_b;
    new_dec  = !(dgt_q || dlt_q) && (slice_gt || slice_lt);
  end

  // Next state, datapath updates and next registered outputs.
  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    tc_n    = tc_q;
    idx_n   = idx_q;
    dgt_n   = dgt_q;
    dlt_n   = dlt_q;

    case (state_q)
      IDLE: begin
        if (valid_i && ready_o) begin
          a_n     = a_i;
          b_n     = b_i;
          tc_n    = tc_i;
          idx_n   = IDX_TOP;
          dgt_n   = 1'b0;
          dlt_n   = 1'b0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (new_dec) begin
          dgt_n = slice_gt;
          dlt_n = slice_lt;
        end
        if (idx_q == '0 || (early_exit && new_dec)) begin
          state_n = DONE;
        end else begin
          idx_n = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (valid_o && ready_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    ready_n = (state_n == IDLE);
    valid_n = (state_n == DONE);
    gt_n    = valid_n && dgt_n;
    lt_n    = valid_n && dlt_n;
    eq_n    = valid_n && !(dgt_n || dlt_n);
  end

  // State, captured operands and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tc_q    <= 1'b0;
      idx_q   <= '0;
      dgt_q   <= 1'b0;
      dlt_q   <= 1'b0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      lt_o    <= 1'b0;
      eq_o    <= 1'b0;
      gt_o    <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      tc_q    <= tc_n;
      idx_q   <= idx_n;
      dgt_q   <= dgt_n;
      dlt_q   <= dlt_n;
      ready_o <= ready_n;
      valid_o <= valid_n;
      lt_o    <= lt_n;
      eq_o    <= eq_n;
      gt_o    <= gt_n;
    end
  end

endmodule

// File: doc/cmp_msb_serial.md
# cmp_msb_serial

Sequential magnitude comparator that resolves A versus B most-significant-chunk first, so decisions flow from MSB toward LSB, the reverse of the LSB-to-MSB generate/propagate carry chain. Each cycle it examines one `chunk`-bit slice. It stops at the first differing slice unless fixed latency is requested. The block sits beside the adder/prefix library as the multi-cycle, area-lean compare unit for wide operands. It uses valid/ready handshakes on both sides.

## Interface
Parameters:
- `width`, 32: operand width in bits. Must be an integer multiple of `chunk`; any other value is an elaboration error.
- `chunk`, 8: bits examined per cycle. Range 1..`width`. NC = `width`/`chunk` is the chunk count.
- `early_exit`, 1: 1 = finish at the first differing chunk; 0 = always scan all NC chunks (fixed latency).

Ports:
- `clk_i`, in, 1: clock. Single clock domain; all state on its rising edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `valid_i`, in, 1: operands valid.
- `ready_o`, out, 1: block can accept operands.
- `a_i`, in, `width`: operand A.
- `b_i`, in, `width`: operand B.
- `tc_i`, in, 1: 1 = two's-complement compare; 0 = unsigned compare.
- `valid_o`, out, 1: result valid.
- `ready_i`, in, 1: downstream accepts result.
- `lt_o`, out, 1: A < B.
- `eq_o`, out, 1: A == B.
- `gt_o`, out, 1: A > B.

## Operation
States: IDLE, SCAN, DONE.

IDLE:
- `ready_o`=1, `valid_o`=0.
- On an accept edge (`valid_i`&`ready_o`): register `a_i`, `b_i`, `tc_i`; set chunk index idx=NC-1; clear decision flags (dgt=dlt=0); go to SCAN.

SCAN:
- `ready_o`=0, `valid_o`=0.
- Each cycle compares slice idx, bits [idx*chunk+chunk-1 : idx*chunk].
- Within a slice, the highest differing bit decides (priority scan toward LSB).
- Signed adjustment: when tc=1 and idx=NC-1, bit `width`-1 of both operands is inverted before the compare. This maps two's complement onto unsigned order.
- Recording a decision: if no decision is recorded yet and the slice differs, set dgt or dlt. Once set, a decision is never overwritten by lower slices.
- Exit to DONE when either:
  - idx==0, or
  - `early_exit`=1 and a decision was made this cycle.
- Otherwise idx decrements.

DONE:
- `valid_o`=1.
- `gt_o`=dgt, `lt_o`=dlt, `eq_o`=~(dgt|dlt). Exactly one of the three is 1.
- Outputs hold stable while `ready_i`=0.
- On `valid_o`&`ready_i`, go to IDLE. No new operand is accepted in that same cycle.

Input handling:
- `valid_i` is ignored outside IDLE.
- `a_i`/`b_i`/`tc_i` are sampled only on the accept edge. Later changes have no effect.

Reset:
- `rst_ni` low forces IDLE immediately (asynchronous).
- `valid_o`=0, `ready_o`=1, `lt_o`=`eq_o`=`gt_o`=0.
- Captured operands, idx and decision flags reset to 0.
- Reset mid-SCAN or mid-DONE discards the operation; no `valid_o` follows.

## Timing
- Accept edge E0. The first SCAN cycle is the cycle after E0 and processes slice NC-1.
- `early_exit`=1, first difference in slice NC-1-j: `valid_o` rises j+1 cycles after E0.
- Equal operands: `valid_o` rises NC cycles after E0.
- `early_exit`=0: `valid_o` rises exactly NC cycles after E0, regardless of data.
- After the output handshake edge, `ready_o`=1 in the next cycle (IDLE). Minimum initiation interval is therefore latency+2 cycles.
- All outputs are driven from registered state. There is no combinational path from `valid_i`, `a_i`, `b_i` or `ready_i` to any output.
- Critical path: one `chunk`-bit priority compare plus the decision-flag update.

## Test plan
With `width`=32, `chunk`=8 (NC=4) unless stated:
1. Equal operands: a=b=0xDEADBEEF, tc=0 -> `eq_o`=1, `valid_o` 4 cycles after the accept edge.
2. Top-slice difference: a=0x80000000, b=0x7FFFFFFF.
   - tc=0 -> `gt_o`=1 after 1 cycle.
   - tc=1 -> `lt_o`=1 after 1 cycle.
   - With `early_exit`=0, both cases take 4 cycles with the same results.
3. Bottom-slice difference: a=0x00000001, b=0x00000002, tc=0 -> `lt_o`=1 after 4 cycles. Signed negative pair a=0xFFFFFFFE, b=0xFFFFFFFF, tc=1 -> `lt_o`=1 after 4 cycles.
4. Backpressure: hold `ready_i`=0 for 5 cycles in DONE while pulsing `valid_i` with new operands.
   - Results and `valid_o` stay constant; `ready_o`=0 throughout.
   - The new operands are not captured.
   - After `ready_i`=1, `ready_o`=1 in the following cycle.
5. Reset mid-SCAN: assert `rst_ni`=0 two cycles after accept -> all outputs take their reset values immediately. After release, `valid_o` stays 0 until a new accept, and the next compare is correct.
6. Random regression, including `chunk`=1 and `chunk`=32 builds, checked against `$signed`/unsigned reference compares:
   - one-hot outputs,
   - latency as specified above,
   - operand changes after accept do not affect results.
